// File: rtl/qs1r_dsp_pkg.sv
// Shared DSP-chain definitions for the QS1R receive path.
// - DSP_IN_WIDTH  : sample width produced by the NCO/CORDIC mixer.
// - DSP_OUT_WIDTH : sample width consumed by the CFIR/FIR decimator.
// - cic_acc_width : CIC accumulator width = in_width + ceil(stages * log2(decimation)).
package qs1r_dsp_pkg;

  localparam int unsigned DSP_IN_WIDTH  = 22;
  localparam int unsigned DSP_OUT_WIDTH = 24;

  // ceil(N * log2(R)) equals ceil(log2(R^N)); R^N fits in 64 bits for R <= 127, N <= 9.
  function automatic int unsigned cic_acc_width(input int unsigned in_width,
                                                input int unsigned stages,
                                                input int unsigned decimation);
    logic [63:0] gain;
    int unsigned growth;
    gain   = 64'd1;
    growth = 0;
    for (int unsigned s = 0; s < stages; s++) gain = gain * 64'(decimation);
    while ((64'd1 << growth) < gain) growth++;
    return in_width + growth;
  endfunction

endpackage

// File: rtl/qs1r_cic_decim_if.sv
// Sample-stream bundle around the CIC decimator.
// - in_strobe/in_I/in_Q    : mixer-side samples (driven by master, read by slave).
// - out_strobe/out_I/out_Q : decimated samples towards the FIR stage (driven by slave).
interface qs1r_cic_decim_if
  import qs1r_dsp_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DSP_IN_WIDTH,
  parameter int unsigned OUT_WIDTH = DSP_OUT_WIDTH
);
  logic                        in_strobe;
  logic signed [IN_WIDTH-1:0]  in_I;
  logic signed [IN_WIDTH-1:0]  in_Q;
  logic                        out_strobe;
  logic signed [OUT_WIDTH-1:0] out_I;
  logic signed [OUT_WIDTH-1:0] out_Q;

  modport master (output in_strobe, in_I, in_Q, input out_strobe, out_I, out_Q);
  modport slave  (input in_strobe, in_I, in_Q, output out_strobe, out_I, out_Q);
endinterface

// File: rtl/qs1r_cic_channel.sv
// One CIC rail: integrator chain, pipelined comb chain and output rounding.
// - clock, reset : system clock, synchronous active-high reset.
// - in_strobe    : advances the integrators.
// - in_data      : signed input sample.
// - comb_en      : per-comb-stage enable (valid travelling down the pipe, from the top).
// - out_en       : loads the rounded comb result into the output register.
// - out_data     : signed, rounded, saturated output (held between loads).
module qs1r_cic_channel
  import qs1r_dsp_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DSP_IN_WIDTH,
  parameter int unsigned STAGES    = 5,
  parameter int unsigned ACC_WIDTH = 49,
  parameter int unsigned OUT_WIDTH = DSP_OUT_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_strobe,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic [STAGES-1:0]           comb_en,
  input  logic                        out_en,
  output logic signed [OUT_WIDTH-1:0] out_data
);
  localparam int unsigned DROP = ACC_WIDTH - OUT_WIDTH;
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  acc_t integ_q [STAGES];
  acc_t comb_q  [STAGES];
  acc_t dly_q   [STAGES];
  acc_t comb_in [STAGES];
  acc_t comb_last;
  logic signed [OUT_WIDTH-1:0] trunc, rounded, out_q;
  logic round_bit;

  // Integrators wrap modulo 2^ACC_WIDTH; the combs cancel the wrap exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) integ_q[k] <= '0;
    end else if (in_strobe) begin
      integ_q[0] <= integ_q[0] + ACC_WIDTH'(in_data);
      for (int k = 1; k < STAGES; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
    end
  end

  always_comb begin
    comb_in[0] = integ_q[STAGES-1];
    for (int k = 1; k < STAGES; k++) comb_in[k] = comb_q[k-1];
  end

  // Round half up on the first dropped bit; only the positive end can overflow.
  always_comb begin
    comb_last = comb_q[STAGES-1];
    trunc     = comb_last[ACC_WIDTH-1 -: OUT_WIDTH];
    round_bit = comb_last[DROP-1];
    rounded   = trunc;
    if (round_bit) begin
      rounded = (trunc == OUT_MAX) ? OUT_MAX : trunc + OUT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        comb_q[k] <= '0;
        dly_q[k]  <= '0;
      end
      out_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (comb_en[k]) begin
          comb_q[k] <= comb_in[k] - dly_q[k];
          dly_q[k]  <= comb_in[k];
        end
      end
      if (out_en) out_q <= rounded;
    end
  end

  assign out_data = out_q;

endmodule

// File: rtl/qs1r_cic_decim.sv
// Decimating CIC filter for the mixer's baseband I/Q stream.
// - clock, reset : system clock, synchronous active-high reset.
// - bus (slave)  : in_strobe/in_I/in_Q from the mixer; out_strobe/out_I/out_Q to the FIR.
// I and Q share the decimation counter, dec_tick and the comb valid pipe, so both rails
// are cycle-identical and a single out_strobe covers them.
module qs1r_cic_decim
  import qs1r_dsp_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = DSP_IN_WIDTH,
  parameter int unsigned STAGES     = 5,
  parameter int unsigned DECIMATION = 40,
  parameter int unsigned ACC_WIDTH  = cic_acc_width(IN_WIDTH, STAGES, DECIMATION),
  parameter int unsigned OUT_WIDTH  = DSP_OUT_WIDTH
) (
  input logic              clock,
  input logic              reset,
  qs1r_cic_decim_if.slave  bus
);
  localparam int unsigned CNT_WIDTH = $clog2(DECIMATION);

  logic [CNT_WIDTH-1:0] count_q;
  logic                 dec_tick_q;
  logic [STAGES-1:0]    comb_valid_q;
  logic [STAGES-1:0]    comb_en;
  logic                 out_strobe_q;

  // Comb stage k fires when stage k-1 produced a value; stage 0 fires on dec_tick.
  always_comb begin
    comb_en = (comb_valid_q << 1) | STAGES'(dec_tick_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= '0;
      dec_tick_q   <= 1'b0;
      comb_valid_q <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      dec_tick_q <= 1'b0;
      if (bus.in_strobe) begin
        if (count_q == CNT_WIDTH'(DECIMATION - 1)) begin
          count_q    <= '0;
          dec_tick_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_WIDTH'(1);
        end
      end
      comb_valid_q <= comb_en;
      out_strobe_q <= comb_valid_q[STAGES-1];
    end
  end

  qs1r_cic_channel #(
    .IN_WIDTH  (IN_WIDTH),
    .STAGES    (STAGES),
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_chan_i (
    .clock     (clock),
    .reset     (reset),
    .in_strobe (bus.in_strobe),
    .in_data   (bus.in_I),
    .comb_en   (comb_en),
    .out_en    (comb_valid_q[STAGES-1]),
    .out_data  (bus.out_I)
  );

  qs1r_cic_channel #(
    .IN_WIDTH  (IN_WIDTH),
    .STAGES    (STAGES),
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_chan_q (
    .clock     (clock),
    .reset     (reset),
    .in_strobe (bus.in_strobe),
    .in_data   (bus.in_Q),
    .comb_en   (comb_en),
    .out_en    (comb_valid_q[STAGES-1]),
    .out_data  (bus.out_Q)
  );

  assign bus.out_strobe = out_strobe_q;

endmodule
